// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback steps and drives every datapath select/enable.
module multicycle_main_fsm #(
  parameter int STATE_W       = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic               Branch,
  output logic               PCUpdate,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               AdrSrc,
  output logic [1:0]         ALUOp,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECUTER = STATE_W'(6),
    S_EXECUTEI = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BEQ      = STATE_W'(9),
    S_JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state, next_state, out_state;
  logic   rdy;

  assign rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_dbg = state;

  // NOTE: state is the only flop; it takes non-blocking assignments so every
  // reader sees the pre-edge value, while the comb blocks below use blocking.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_I:         next_state = S_EXECUTEI;
          OP_JAL:       next_state = S_JAL;
          OP_BEQ:       next_state = S_BEQ;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // While reset is held the outputs look like FETCH, so a mid-instruction
  // reset never fires a register or memory write.
  assign out_state = reset ? S_FETCH : state;

  // NOTE: every output gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    Branch        = 1'b0;
    PCUpdate      = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    AdrSrc        = 1'b0;
    ALUOp         = 2'b00;
    illegal_instr = 1'b0;
    case (out_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCUpdate  = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_instr = 1'b0;
          default:                                  illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
